// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and constants for the axis_pkt_fifo store-and-forward packet FIFO.
package axis_pkt_fifo_pkg;

    typedef enum logic {
        LOAD,
        DROP
    } wr_state_t;

    localparam int DROP_CNT_WIDTH = 16;

    // Width of one stored beat: {tlast, tuser, tkeep, tdata}.
    function automatic int entry_width(input int data_width, input int user_width);
        return 1 + user_width + data_width / 8 + data_width;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream bundle used on both sides of axis_pkt_fifo.
interface axis_interface #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port beat storage with a registered read port.
module axis_pkt_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port and registered read port; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: packets are offered downstream only
// after their tlast beat is stored; oversize packets are discarded and counted.
// Optional: define AXIS_PKT_FIFO_ERR_DROP_EN to drop packets whose tlast beat
// carries tuser[0]=1 (and clear tuser[0] on the output).
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_PKTS   = 16
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst,
    axis_interface.slave              axis_load,
    axis_interface.master             axis_unload,
    output logic [$clog2(MAX_PKTS):0] pkt_count,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = entry_width(DATA_WIDTH, USER_WIDTH);
    localparam int CW = $clog2(MAX_PKTS) + 1;

    wr_state_t               state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           pkt_count_q, pkt_count_d;
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    out_valid_q, out_valid_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [EW-1:0]           out_entry_q, out_entry_d;
    logic [EW-1:0]           skid_entry_q, skid_entry_d;

    logic                    full, load_ready, wr_en, commit, drop_inc, err_tlast;
    logic                    rd_en, out_hs, unload_last;
    logic [1:0]              occ;
    logic [USER_WIDTH-1:0]   wr_user;
    logic [EW-1:0]           wr_entry, ram_dout;

    assign full  = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
    assign wr_en = (state_q == LOAD) && axis_load.tvalid && load_ready;

`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
    assign err_tlast = axis_load.tuser[0];
    assign wr_user   = axis_load.tuser & ~USER_WIDTH'(1);
`else
    assign err_tlast = 1'b0;
    assign wr_user   = axis_load.tuser;
`endif

    assign wr_entry = {axis_load.tlast, wr_user, axis_load.tkeep, axis_load.tdata};

    // Write FSM: accept/commit beats in LOAD, swallow the rest of an oversize packet in DROP.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        load_ready   = 1'b0;
        commit       = 1'b0;
        drop_inc     = 1'b0;
        case (state_q)
            LOAD: begin
                load_ready = ~axis_rst & ~full & (pkt_count_q < CW'(MAX_PKTS));
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (axis_load.tlast) begin
                        if (err_tlast) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = 1'b1;
                        end else begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            commit       = 1'b1;
                        end
                    end
                end else if (full && (commit_ptr_q == rd_ptr_q) && axis_load.tvalid) begin
                    // The whole buffer holds one unfinished packet: it can never fit.
                    wr_ptr_d = commit_ptr_q;
                    state_d  = DROP;
                end
            end
            DROP: begin
                load_ready = ~axis_rst;
                if (axis_load.tvalid && axis_load.tlast) begin
                    drop_inc = 1'b1;
                    state_d  = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign occ         = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_valid_q);
    assign out_hs      = out_valid_q & axis_unload.tready;
    assign unload_last = out_hs & out_entry_q[EW-1];
    // Issue a RAM read only if the out/skid pair can absorb it next cycle.
    assign rd_en       = (rd_ptr_q != commit_ptr_q) && ((occ - 2'(out_hs)) < 2'd2);

    // Counters and read pointer.
    always_comb begin
        rd_ptr_d     = rd_ptr_q + PW'(rd_en);
        rd_valid_d   = rd_en;
        pkt_count_d  = pkt_count_q;
        drop_count_d = drop_count_q;
        case ({commit, unload_last})
            2'b10:   pkt_count_d = pkt_count_q + CW'(1);
            2'b01:   pkt_count_d = pkt_count_q - CW'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
        if (drop_inc && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
    end

    // Output register plus skid, behaving as a two-entry queue with out as head.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_entry_d  = out_entry_q;
        skid_valid_d = skid_valid_q;
        skid_entry_d = skid_entry_q;
        if (out_hs) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_entry_d  = skid_entry_q;
                skid_valid_d = rd_valid_q;
                skid_entry_d = rd_valid_q ? ram_dout : '0;
            end else begin
                out_valid_d  = rd_valid_q;
                out_entry_d  = rd_valid_q ? ram_dout : '0;
            end
        end else if (rd_valid_q) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_entry_d = ram_dout;
            end else begin
                skid_valid_d = 1'b1;
                skid_entry_d = ram_dout;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            rd_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_entry_q  <= '0;
            skid_entry_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            rd_valid_q   <= rd_valid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_entry_q  <= out_entry_d;
            skid_entry_q <= skid_entry_d;
        end
    end

    axis_pkt_fifo_ram #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk     (axis_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_dout)
    );

    assign axis_load.tready   = load_ready;
    assign axis_unload.tvalid = out_valid_q;
    assign axis_unload.tdata  = out_entry_q[DATA_WIDTH-1:0];
    assign axis_unload.tkeep  = out_entry_q[DATA_WIDTH +: KW];
    assign axis_unload.tuser  = out_entry_q[DATA_WIDTH+KW +: USER_WIDTH];
    assign axis_unload.tlast  = out_entry_q[EW-1];
    assign pkt_count          = pkt_count_q;
    assign drop_count         = drop_count_q;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo (optionally built with AXIS_PKT_FIFO_ERR_DROP_EN).
module tb_axis_pkt_fifo;
    localparam int DW = 32;
    localparam int UW = 1;
    localparam int KW = DW / 8;
    localparam int EW = 1 + UW + KW + DW;
`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic [4:0]  pkt_count;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q [$];

    always #5 axis_clk = ~axis_clk;

    axis_interface #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) ld ();
    axis_interface #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) ul ();

    axis_pkt_fifo #(
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW),
        .FIFO_DEPTH (64),
        .MAX_PKTS   (16)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst    (axis_rst),
        .axis_load   (ld),
        .axis_unload (ul),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one beat, wait (bounded) for tready, and record it if it should reappear.
    task automatic send(input logic [DW-1:0] d, input logic u, input logic l, input bit expect_out);
        int unsigned n = 0;
        ld.tvalid = 1'b1; ld.tdata = d; ld.tkeep = 4'hF; ld.tuser = u; ld.tlast = l;
        @(negedge axis_clk);
        while (!ld.tready && n < 2000) begin
            @(negedge axis_clk);
            n++;
        end
        if (!ld.tready) begin
            check("load_tready_timeout", 64'(ld.tready), 64'd1);
        end else if (expect_out) begin
            exp_q.push_back({l, (ERR_EN ? 1'b0 : u), 4'hF, d});
        end
        @(posedge axis_clk);
        #1;
        ld.tvalid = 1'b0; ld.tdata = '0; ld.tkeep = '0; ld.tuser = '0; ld.tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_q.size() != 0 || ul.tvalid) && n < 500) begin
            @(negedge axis_clk);
            n++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pop and compare every unload handshake; idle payload must be zero.
    always @(negedge axis_clk) begin
        if (!axis_rst) begin
            if (ul.tvalid && ul.tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'({ul.tlast, ul.tuser, ul.tkeep, ul.tdata}), 64'd0);
                end else begin
                    check("unload_beat", 64'({ul.tlast, ul.tuser, ul.tkeep, ul.tdata}),
                          64'(exp_q.pop_front()));
                end
            end else if (!ul.tvalid) begin
                check("idle_payload_zero", 64'({ul.tlast, ul.tuser, ul.tkeep, ul.tdata}), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_rst  = 1'b1;
        ld.tvalid = 1'b0; ld.tdata = '0; ld.tkeep = '0; ld.tuser = '0; ld.tlast = 1'b0;
        ul.tready = 1'b0;

        // Reset values
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check("rst_load_tready", 64'(ld.tready), 64'd0);
        check("rst_unload_tvalid", 64'(ul.tvalid), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        @(negedge axis_clk);
        check("post_rst_load_tready", 64'(ld.tready), 64'd1);
        @(posedge axis_clk); #1;

        // 3-beat packet: tvalid two cycles after tlast accept
        ul.tready = 1'b1;
        send(32'hA1, 1'b0, 1'b0, 1);
        send(32'hA2, 1'b1, 1'b0, 1);
        send(32'hA3, 1'b0, 1'b1, 1);
        @(negedge axis_clk);
        check("lat_pkt_count", 64'(pkt_count), 64'd1);
        check("lat_tvalid_c0", 64'(ul.tvalid), 64'd0);
        @(negedge axis_clk);
        check("lat_tvalid_c1", 64'(ul.tvalid), 64'd0);
        @(negedge axis_clk);
        check("lat_tvalid_c2", 64'(ul.tvalid), 64'd1);
        wait_drain();
        check("lat_pkt_count_end", 64'(pkt_count), 64'd0);
        @(posedge axis_clk); #1;

        // Held-back tlast: nothing offered until the packet is complete
        send(32'hB1, 1'b0, 1'b0, 1);
        send(32'hB2, 1'b0, 1'b0, 1);
        send(32'hB3, 1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge axis_clk);
            check("hold_no_tvalid", 64'(ul.tvalid), 64'd0);
        end
        @(posedge axis_clk); #1;
        send(32'hB4, 1'b0, 1'b1, 1);
        wait_drain();
        @(posedge axis_clk); #1;

        // Oversize 70-beat packet dropped, following 2-beat packet intact
        for (int i = 0; i < 70; i++) send(32'h700 + 32'(i), 1'b0, (i == 69), 0);
        send(32'hC1, 1'b0, 1'b0, 1);
        send(32'hC2, 1'b0, 1'b1, 1);
        wait_drain();
        check("oversize_drop_count", 64'(drop_count), 64'd1);
        @(posedge axis_clk); #1;

        // Sixteen single-beat packets with unload stalled, 17th back-pressured
        ul.tready = 1'b0;
        for (int i = 0; i < 16; i++) send(32'h800 + 32'(i), 1'b0, 1'b1, 1);
        ld.tvalid = 1'b1; ld.tdata = 32'h810; ld.tkeep = 4'hF; ld.tuser = 1'b0; ld.tlast = 1'b1;
        @(negedge axis_clk);
        check("fill_pkt_count", 64'(pkt_count), 64'd16);
        check("fill_tready_17th", 64'(ld.tready), 64'd0);
        @(posedge axis_clk); #1;
        ul.tready = 1'b1;
        send(32'h810, 1'b0, 1'b1, 1);
        wait_drain();
        check("fill_pkt_count_end", 64'(pkt_count), 64'd0);
        @(posedge axis_clk); #1;

        // Steady single-beat traffic: commits and unloads balance, no bubbles
        fork
            begin
                for (int i = 0; i < 20; i++) send(32'h900 + 32'(i), 1'b0, 1'b1, 1);
            end
            begin
                int unsigned n = 0;
                @(negedge axis_clk);
                while (!ul.tvalid && n < 50) begin
                    @(negedge axis_clk);
                    n++;
                end
                for (int i = 0; i < 20; i++) begin
                    if (i > 0) @(negedge axis_clk);
                    check("steady_no_bubble", 64'(ul.tvalid), 64'd1);
                    if (i <= 17) check("steady_pkt_count", 64'(pkt_count), 64'd3);
                end
            end
        join
        wait_drain();
        @(posedge axis_clk); #1;

        // Reset mid-packet discards committed and partial content
        ul.tready = 1'b0;
        send(32'hD00, 1'b0, 1'b1, 1);
        send(32'hD10, 1'b0, 1'b0, 0);
        repeat (3) @(negedge axis_clk);
        check("pre_rst_tvalid", 64'(ul.tvalid), 64'd1);
        @(posedge axis_clk); #1;
        axis_rst = 1'b1;
        exp_q.delete();
        @(negedge axis_clk);
        check("mid_rst_load_tready", 64'(ld.tready), 64'd0);
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        @(negedge axis_clk);
        check("post_rst_tvalid", 64'(ul.tvalid), 64'd0);
        check("post_rst_pkt_count", 64'(pkt_count), 64'd0);
        check("post_rst_drop_count", 64'(drop_count), 64'd0);
        check("post_rst_tready", 64'(ld.tready), 64'd1);
        @(posedge axis_clk); #1;
        ul.tready = 1'b1;
        send(32'hD20, 1'b0, 1'b0, 1);
        send(32'hD21, 1'b0, 1'b1, 1);
        wait_drain();
        @(posedge axis_clk); #1;

`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
        // Errored packet (tuser[0] on tlast) dropped; clean one follows with tuser cleared
        send(32'hE0, 1'b0, 1'b0, 0);
        send(32'hE1, 1'b1, 1'b1, 0);
        send(32'hF0, 1'b1, 1'b0, 1);
        send(32'hF1, 1'b0, 1'b1, 1);
        wait_drain();
        check("err_drop_count", 64'(drop_count), 64'd1);
        check("err_pkt_count", 64'(pkt_count), 64'd0);
`else
        // Transparent tuser on a tlast beat
        send(32'hF2, 1'b1, 1'b1, 1);
        wait_drain();
        check("plain_drop_count", 64'(drop_count), 64'd0);
`endif

        repeat (3) @(posedge axis_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
